// File: rtl/border_gen_pkg.sv
// Shared pixel-stream definitions for the vo_clk video pipeline stages.
// RGB888 packing, position counter widths and a clog2 helper.
package border_gen_pkg;

    localparam int PIX_W  = 24;
    localparam int FCNT_W = 8;
    localparam int MAX_DIM = 1920;

    // r occupies the MSBs of the 24-bit pixel word
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    localparam int POS_W = clog2_f(MAX_DIM);

endpackage

// File: rtl/vid_pos_cntr.sv
// Pixel x/y tracker with eof > eol > req > vsync priority.
// Also keeps sticky line/frame length mismatch flags.
module vid_pos_cntr
    import border_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             req,
    input  logic             eol,
    input  logic             eof,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             line_err,
    output logic             frame_err
);

    localparam logic [POS_W-1:0] X_LAST = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_ACTIVE - 1);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             line_err_q, line_err_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        if (req && eol && (x_q != X_LAST)) line_err_d = 1'b1;
        if (req && eof && ((x_q != X_LAST) || (y_q != Y_LAST))) frame_err_d = 1'b1;
        if (req && eof) begin
            x_d = '0;
            y_d = '0;
        end else if (req && eol) begin
            x_d = '0;
            y_d = (y_q == '1) ? y_q : y_q + POS_W'(1);
        end else if (req) begin
            x_d = (x_q == '1) ? x_q : x_q + POS_W'(1);
        end else if (vsync) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/border_gen.sv
// Solid (optionally blinking) border overlay on the vo_clk pixel stream.
// Config is shadowed at eof so a frame never tears; one cycle of latency.
module border_gen
    import border_gen_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BORDER_W  = 8,
    parameter int BLINK_BIT = 5
) (
    input  logic             vo_clk,
    input  logic             vo_reset,
    input  logic             in_vsync,
    input  logic             in_req,
    input  logic             in_eol,
    input  logic             in_eof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             border_en,
    input  logic             blink_en,
    input  logic [PIX_W-1:0] border_color,
    output logic             out_vsync,
    output logic             out_req,
    output logic             out_eol,
    output logic             out_eof,
    output logic [PIX_W-1:0] out_pixel,
    output logic             line_err,
    output logic             frame_err
);

    localparam logic [POS_W-1:0] BW_L = POS_W'(BORDER_W);
    localparam logic [POS_W-1:0] X_RB = POS_W'(H_ACTIVE - BORDER_W);
    localparam logic [POS_W-1:0] Y_BB = POS_W'(V_ACTIVE - BORDER_W);

    logic [POS_W-1:0] x, y;

    logic              vsync_q, req_q, eol_q, eof_q;
    rgb_t              pixel_q, pixel_d;
    logic              sh_en_q, sh_en_d;
    logic              sh_blink_q, sh_blink_d;
    rgb_t              sh_color_q, sh_color_d;
    logic [FCNT_W-1:0] frame_cntr_q, frame_cntr_d;
    logic              first_q;
    logic              in_border, show, load;

    vid_pos_cntr #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk       (vo_clk),
        .rst       (vo_reset),
        .vsync     (in_vsync),
        .req       (in_req),
        .eol       (in_eol),
        .eof       (in_eof),
        .x         (x),
        .y         (y),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always_comb begin
        in_border = (x < BW_L) | (x >= X_RB) | (y < BW_L) | (y >= Y_BB);
        show      = sh_en_q & in_border & (~sh_blink_q | frame_cntr_q[BLINK_BIT]);
        load      = (in_req & in_eof) | first_q;

        pixel_d      = pixel_q;
        sh_en_d      = sh_en_q;
        sh_blink_d   = sh_blink_q;
        sh_color_d   = sh_color_q;
        frame_cntr_d = frame_cntr_q;

        if (in_req) pixel_d = show ? sh_color_q : rgb_t'(in_pixel);
        // first_q picks up the config that was set up while in reset
        if (load) begin
            sh_en_d    = border_en;
            sh_blink_d = blink_en;
            sh_color_d = rgb_t'(border_color);
        end
        if (in_req && in_eof) frame_cntr_d = frame_cntr_q + FCNT_W'(1);
    end

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            vsync_q      <= 1'b0;
            req_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            pixel_q      <= '0;
            sh_en_q      <= 1'b0;
            sh_blink_q   <= 1'b0;
            sh_color_q   <= '0;
            frame_cntr_q <= '0;
            first_q      <= 1'b1;
        end else begin
            vsync_q      <= in_vsync;
            req_q        <= in_req;
            eol_q        <= in_eol;
            eof_q        <= in_eof;
            pixel_q      <= pixel_d;
            sh_en_q      <= sh_en_d;
            sh_blink_q   <= sh_blink_d;
            sh_color_q   <= sh_color_d;
            frame_cntr_q <= frame_cntr_d;
            first_q      <= 1'b0;
        end
    end

    assign out_vsync = vsync_q;
    assign out_req   = req_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign out_pixel = pixel_q;

endmodule

// File: tb/tb_border_gen.sv
// Scoreboard bench for border_gen on a reduced 24x20 raster.
// Driver pushes model expectations; monitor pops one per cycle.
module tb_border_gen;

    localparam int H  = 24;
    localparam int V  = 20;
    localparam int BW = 4;
    localparam int BB = 5;

    logic        vo_clk = 1'b0;
    logic        vo_reset = 1'b1;
    logic        in_vsync = 1'b0, in_req = 1'b0, in_eol = 1'b0, in_eof = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        border_en = 1'b0, blink_en = 1'b0;
    logic [23:0] border_color = '0;
    logic        out_vsync, out_req, out_eol, out_eof;
    logic [23:0] out_pixel;
    logic        line_err, frame_err;

    always #5 vo_clk = ~vo_clk;

    border_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BORDER_W (BW),
        .BLINK_BIT(BB)
    ) dut (
        .vo_clk      (vo_clk),
        .vo_reset    (vo_reset),
        .in_vsync    (in_vsync),
        .in_req      (in_req),
        .in_eol      (in_eol),
        .in_eof      (in_eof),
        .in_pixel    (in_pixel),
        .border_en   (border_en),
        .blink_en    (blink_en),
        .border_color(border_color),
        .out_vsync   (out_vsync),
        .out_req     (out_req),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .out_pixel   (out_pixel),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    typedef struct {
        bit        vs, rq, eol, eof;
        bit [23:0] pix;
        bit        le, fe;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int        mx, my, mfc;
    bit        m_en, m_bl, m_first, m_le, m_fe;
    bit [23:0] m_col, m_pix;

    bit        cfg_en, cfg_bl;
    bit [23:0] cfg_col;

    task automatic model_step();
        exp_t e;
        bit   border, lit;
        e = '{default: 0};
        if (vo_reset) begin
            mx = 0; my = 0; mfc = 0;
            m_en = 0; m_bl = 0; m_col = 0;
            m_first = 1; m_le = 0; m_fe = 0; m_pix = 0;
        end else begin
            border = (mx < BW) || (mx >= H - BW) || (my < BW) || (my >= V - BW);
            lit = m_en && border && (!m_bl || (((mfc >> BB) & 1) != 0));
            if (in_req) m_pix = lit ? m_col : in_pixel;
            if (in_req && in_eol && mx != H - 1) m_le = 1;
            if (in_req && in_eof && (mx != H - 1 || my != V - 1)) m_fe = 1;
            e.vs = in_vsync; e.rq = in_req; e.eol = in_eol; e.eof = in_eof;
            e.pix = m_pix; e.le = m_le; e.fe = m_fe;
            if ((in_req && in_eof) || m_first) begin
                m_en = border_en; m_bl = blink_en; m_col = border_color;
            end
            m_first = 0;
            if (in_req && in_eof) mfc = (mfc + 1) % 256;
            if (in_req && in_eof) begin
                mx = 0; my = 0;
            end else if (in_req && in_eol) begin
                mx = 0; my = (my < 2047) ? my + 1 : 2047;
            end else if (in_req) begin
                mx = (mx < 2047) ? mx + 1 : 2047;
            end else if (in_vsync) begin
                mx = 0; my = 0;
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit vs, input bit rq,
                        input bit eol, input bit eof, input bit [23:0] pix);
        @(negedge vo_clk);
        vo_reset = rst; in_vsync = vs; in_req = rq;
        in_eol = eol; in_eof = eof; in_pixel = pix;
        border_en = cfg_en; blink_en = cfg_bl; border_color = cfg_col;
        model_step();
    endtask

    // idle slots carry junk eol/eof, which must be ignored without req
    task automatic send_line(input int len, input bit last, input int gmin,
                             input int gmax, input bit rnd, input bit [23:0] fpix);
        for (int i = 0; i < len; i++) begin
            int g;
            g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++)
                step(0, 0, 0, 1'($urandom), 1'($urandom), 24'($urandom));
            step(0, 0, 1, i == len - 1, last && (i == len - 1),
                 rnd ? 24'($urandom) : fpix);
        end
    endtask

    task automatic send_frame(input int gmin, input int gmax,
                              input bit rnd, input bit [23:0] fpix);
        for (int l = 0; l < V; l++) send_line(H, l == V - 1, gmin, gmax, rnd, fpix);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge vo_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if (out_pixel !== e.pix) begin
                    n_fail++;
                    $display("FAIL pixel: got %h expected %h", out_pixel, e.pix);
                end
                n_chk++;
                if ({out_vsync, out_req, out_eol, out_eof} !== {e.vs, e.rq, e.eol, e.eof}) begin
                    n_fail++;
                    $display("FAIL ctrl: got %b expected %b",
                             {out_vsync, out_req, out_eol, out_eof},
                             {e.vs, e.rq, e.eol, e.eof});
                end
                n_chk++;
                if ({line_err, frame_err} !== {e.le, e.fe}) begin
                    n_fail++;
                    $display("FAIL errflags: got %b expected %b",
                             {line_err, frame_err}, {e.le, e.fe});
                end
            end
        end
    end

    initial begin : driver
        cfg_en = 1; cfg_bl = 0; cfg_col = 24'hFF0000;
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 0, 24'h00FF00);

        cfg_en = 0;
        send_frame(0, 1, 1, 0);
        for (int l = 0; l < V; l++) begin
            if (l == 10) cfg_en = 1;
            send_line(H, l == V - 1, 0, 1, 1, 0);
        end
        send_frame(0, 0, 1, 0);

        send_frame(2, 2, 1, 0);

        cfg_bl = 1; cfg_col = 24'($urandom);
        for (int f = 0; f < 64; f++) send_frame(0, 1, 1, 0);
        cfg_bl = 0;

        send_line(13, 0, 0, 0, 1, 0);
        for (int l = 1; l < V - 1; l++) send_line(H, 0, 0, 0, 1, 0);
        send_line(9, 1, 0, 0, 1, 0);
        send_frame(0, 0, 1, 0);

        send_line(10, 0, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int l = 0; l < 6; l++) send_line(H, 0, 0, 0, 1, 0);
        send_line(12, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        send_frame(0, 0, 1, 0);

        step(0, 1, 1, 0, 0, 24'h123456);
        send_line(2100, 0, 0, 0, 1, 0);
        send_frame(0, 0, 1, 0);

        for (int i = 0; i < 2000; i++) begin
            if ((i % 500) == 0) cfg_en = 1'($urandom);
            step(0, ($urandom_range(15, 0) == 0), 1'($urandom),
                 ($urandom_range(7, 0) == 0), ($urandom_range(40, 0) == 0),
                 24'($urandom));
        end

        repeat (3) step(0, 0, 0, 0, 0, 0);
        @(posedge vo_clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
